// File: rtl/gift_decrypt_control_pkg.sv
// gift_decrypt_control_pkg: shared GIFT round count, counter width and controller state encodings.
`default_nettype none

package gift_decrypt_control_pkg;

  localparam int GIFT_ROUNDS = 40;
  localparam int GIFT_CNT_W  = 8;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_KFWD = 2'b01;
  localparam logic [1:0] ST_INV  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

endpackage

`default_nettype wire

// File: rtl/gift_round_counter.sv
// gift_round_counter: clear/enable up-counter with a terminal flag against a runtime limit.
`default_nettype none

module gift_round_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over enable so a phase change restarts the count from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == limit_i);

endmodule

`default_nettype wire

// File: rtl/gift_decrypt_control.sv
// gift_decrypt_control: runs the key schedule forward ROUNDS-1 times, then ROUNDS inverse
// rounds stepping the key back, then captures the plaintext.
`default_nettype none

module gift_decrypt_control
  import gift_decrypt_control_pkg::*;
#(
  parameter int ROUNDS = GIFT_ROUNDS,
  parameter int CNT_W  = GIFT_CNT_W
) (
  input  logic             inClk,
  input  logic             inRst,
  input  logic             inExtKeyWr,
  input  logic             inExtDataWr,
  output logic             outIntKeyschRegExtWr,
  output logic             outIntKeyschRegFwdWr,
  output logic             outIntKeyschRegInvWr,
  output logic             outIntRoundRegExtWr,
  output logic             outIntRoundRegIntWr,
  output logic             outIntDataOutRegWr,
  output logic [CNT_W-1:0] outRoundIdx,
  output logic             outBusy
);

  localparam logic [CNT_W-1:0] LIM_KFWD = CNT_W'(ROUNDS - 2);
  localparam logic [CNT_W-1:0] LIM_INV  = CNT_W'(ROUNDS - 1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_limit;
  logic             cnt_last;
  logic             cnt_en;
  logic             cnt_clr;
  logic             st_idle;
  logic             st_kfwd;
  logic             st_inv;
  logic             start;

  assign st_idle   = (state_q == ST_IDLE);
  assign st_kfwd   = (state_q == ST_KFWD);
  assign st_inv    = (state_q == ST_INV);
  assign start     = st_idle && inExtDataWr;
  assign cnt_en    = st_kfwd || st_inv;
  assign cnt_clr   = start || (cnt_en && cnt_last);
  assign cnt_limit = st_inv ? LIM_INV : LIM_KFWD;

  gift_round_counter #(
    .CNT_W (CNT_W)
  ) u_round_counter (
    .clk_i   (inClk),
    .rst_i   (inRst),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .limit_i (cnt_limit),
    .cnt_o   (cnt),
    .last_o  (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (inExtDataWr) state_d = ST_KFWD;
      ST_KFWD: if (cnt_last) state_d = ST_INV;
      ST_INV:  if (cnt_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Pass-throughs are gated by reset because the state alone reads IDLE during reset.
  assign outIntKeyschRegExtWr = st_idle && !inRst && inExtKeyWr;
  assign outIntRoundRegExtWr  = st_idle && !inRst && inExtDataWr;
  assign outIntKeyschRegFwdWr = st_kfwd;
  assign outIntKeyschRegInvWr = st_inv && !cnt_last;
  assign outIntRoundRegIntWr  = st_inv;
  assign outIntDataOutRegWr   = (state_q == ST_DONE);
  assign outRoundIdx          = st_inv ? (LIM_INV - cnt) : '0;
  assign outBusy              = !st_idle;

endmodule

`default_nettype wire
